// File: rtl/cp0_pkg.sv
// ----------------------------------------------------------------------------
// cp0_pkg
// Shared definitions for the CP0 exception/interrupt controller:
//   - CP0 register numbers used by MFC0/MTC0
//   - ExcCode values written into Cause on an exception take
//   - controller state enum (RUN / FLUSH)
// ----------------------------------------------------------------------------
package cp0_pkg;

    // CP0 register numbers
    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    // Exception codes (Cause.ExcCode)
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;
    localparam logic [4:0] EXC_DIV0 = 5'd15;

    // RUN accepts exceptions; FLUSH blanks them while the pipeline drains
    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } cp0_state_t;

endpackage

// File: rtl/cp0_exc_prio.sv
// ----------------------------------------------------------------------------
// cp0_exc_prio
// Combinational priority encoder for exception causes.
// Ports:
//   enable_i       controller is in a state that may take exceptions
//   commit_valid_i an instruction is present at commit
//   int_i          enabled, unmasked interrupt pending
//   overflow_i, divzero_i, syscall_i, brk_i, ri_i   synchronous causes
//   take_o         an exception is taken this cycle
//   exc_code_o     ExcCode of the winning cause (EXC_INT when none)
// Priority: interrupt > overflow > divzero > syscall > break > reserved instr.
// ----------------------------------------------------------------------------
module cp0_exc_prio
    import cp0_pkg::*;
(
    input  logic       enable_i,
    input  logic       commit_valid_i,
    input  logic       int_i,
    input  logic       overflow_i,
    input  logic       divzero_i,
    input  logic       syscall_i,
    input  logic       brk_i,
    input  logic       ri_i,
    output logic       take_o,
    output logic [4:0] exc_code_o
);

    // Every cause, interrupts included, needs a committing instruction so
    // that EPC has a meaningful PC to record.
    always_comb begin
        take_o     = 1'b0;
        exc_code_o = EXC_INT;
        if (enable_i && commit_valid_i) begin
            if (int_i) begin
                take_o     = 1'b1;
                exc_code_o = EXC_INT;
            end else if (overflow_i) begin
                take_o     = 1'b1;
                exc_code_o = EXC_OV;
            end else if (divzero_i) begin
                take_o     = 1'b1;
                exc_code_o = EXC_DIV0;
            end else if (syscall_i) begin
                take_o     = 1'b1;
                exc_code_o = EXC_SYS;
            end else if (brk_i) begin
                take_o     = 1'b1;
                exc_code_o = EXC_BP;
            end else if (ri_i) begin
                take_o     = 1'b1;
                exc_code_o = EXC_RI;
            end
        end
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// ----------------------------------------------------------------------------
// cp0_exc_ctrl
// CP0 exception/interrupt controller sitting beside the commit stage.
// Owns Status, Cause and EPC, prioritises interrupts and synchronous causes,
// redirects fetch to EXC_VECTOR and blanks further exceptions for FLUSH_CYC
// cycles after each take. Serves MFC0 (combinational read), MTC0 and RFE.
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   irq_i                   level interrupt lines (only [NUM_IRQ-1:2] used)
//   commit_valid_i/pc_i/bd_i  committing instruction, its PC, delay-slot flag
//   syscall_i, brk_i, ri_i, overflow_i, divzero_i   synchronous causes
//   rfe_i                   RFE committing
//   cp0_we_i/addr_i/wdata_i MTC0 write port
//   cp0_rdata_o             MFC0 read data (combinational)
//   exc_take_o              exception taken this cycle (combinational)
//   exc_redirect_o          registered one-cycle redirect pulse
//   exc_pc_o                exception vector (constant)
//   exc_busy_o              high while in FLUSH
// ----------------------------------------------------------------------------
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter int                NUM_IRQ    = 8,
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] EXC_VECTOR = 32'h8000_0080,
    parameter int                FLUSH_CYC  = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               commit_valid_i,
    input  logic [DATA_W-1:0]  commit_pc_i,
    input  logic               commit_bd_i,
    input  logic               syscall_i,
    input  logic               brk_i,
    input  logic               ri_i,
    input  logic               overflow_i,
    input  logic               divzero_i,
    input  logic               rfe_i,
    input  logic               cp0_we_i,
    input  logic [4:0]         cp0_addr_i,
    input  logic [DATA_W-1:0]  cp0_wdata_i,
    output logic [DATA_W-1:0]  cp0_rdata_o,
    output logic               exc_take_o,
    output logic               exc_redirect_o,
    output logic [DATA_W-1:0]  exc_pc_o,
    output logic               exc_busy_o
);

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYC - 1);

    // Architectural state
    cp0_state_t          state_q, state_d;
    logic [3:0]          flushCnt_q;
    logic                redirect_q;
    logic [5:0]          statusLow_q, statusLow_d;   // KUo IEo KUp IEp KUc IEc
    logic [NUM_IRQ-1:0]  im_q, im_d;
    logic [NUM_IRQ-1:0]  ip_q, ip_d;
    logic [4:0]          excCode_q, excCode_d;
    logic                bd_q, bd_d;
    logic [DATA_W-1:0]   epc_q, epc_d;

    // Control
    logic                runState;
    logic                intPending;
    logic                take;
    logic [4:0]          takeCode;
    logic                rfeEn;
    logic                mtc0En;
    logic [DATA_W-1:0]   statusRd;
    logic [DATA_W-1:0]   causeRd;
    logic                unusedIrqSw;

    // Software IRQ lines on the irq port have no meaning; IP[1:0] come
    // from MTC0 Cause only.
    assign unusedIrqSw = ^irq_i[1:0];

    // Interrupt is pending when globally enabled and any unmasked IP bit set
    assign intPending = statusLow_q[0] & (|(ip_q & im_q));

    cp0_exc_prio u_prio (
        .enable_i       (runState),
        .commit_valid_i (commit_valid_i),
        .int_i          (intPending),
        .overflow_i     (overflow_i),
        .divzero_i      (divzero_i),
        .syscall_i      (syscall_i),
        .brk_i          (brk_i),
        .ri_i           (ri_i),
        .take_o         (take),
        .exc_code_o     (takeCode)
    );

    // A take squashes the committing RFE/MTC0; RFE in turn beats MTC0.
    assign rfeEn  = runState & commit_valid_i & rfe_i & ~take;
    assign mtc0En = runState & cp0_we_i & ~take & ~rfeEn;

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: FLUSH lasts until the counter has reached zero
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (take) state_d = FLUSH;
            FLUSH:   if (flushCnt_q == 4'd0) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        runState   = 1'b0;
        exc_busy_o = 1'b0;
        case (state_q)
            RUN:     runState   = 1'b1;
            FLUSH:   exc_busy_o = 1'b1;
            default: runState   = 1'b1;
        endcase
    end

    // Flush counter and the one-cycle redirect pulse
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            flushCnt_q <= 4'd0;
            redirect_q <= 1'b0;
        end else begin
            redirect_q <= take;
            if (take) begin
                flushCnt_q <= FLUSH_INIT;
            end else if (state_q == FLUSH && flushCnt_q != 4'd0) begin
                flushCnt_q <= flushCnt_q - 4'd1;
            end
        end
    end

    // Next values of Status/Cause/EPC; hw IP bits always track irq,
    // regardless of any MTC0 Cause in the same cycle.
    always_comb begin
        statusLow_d = statusLow_q;
        im_d        = im_q;
        excCode_d   = excCode_q;
        bd_d        = bd_q;
        epc_d       = epc_q;
        ip_d        = ip_q;
        for (int i = 2; i < NUM_IRQ; i++) begin
            ip_d[i] = irq_i[i];
        end
        if (take) begin
            statusLow_d = {statusLow_q[3:0], 2'b00};
            excCode_d   = takeCode;
            bd_d        = commit_bd_i;
            epc_d       = commit_bd_i ? (commit_pc_i - DATA_W'(4)) : commit_pc_i;
        end else if (rfeEn) begin
            statusLow_d[3:0] = statusLow_q[5:2];
        end else if (mtc0En) begin
            case (cp0_addr_i)
                CP0_STATUS: begin
                    statusLow_d = cp0_wdata_i[5:0];
                    im_d        = cp0_wdata_i[8 +: NUM_IRQ];
                end
                CP0_CAUSE: begin
                    ip_d[1:0] = cp0_wdata_i[9:8];
                end
                CP0_EPC: begin
                    epc_d = cp0_wdata_i;
                end
                default: begin
                end
            endcase
        end
    end

    // CP0 register file
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            statusLow_q <= '0;
            im_q        <= '0;
            ip_q        <= '0;
            excCode_q   <= '0;
            bd_q        <= 1'b0;
            epc_q       <= '0;
        end else begin
            statusLow_q <= statusLow_d;
            im_q        <= im_d;
            ip_q        <= ip_d;
            excCode_q   <= excCode_d;
            bd_q        <= bd_d;
            epc_q       <= epc_d;
        end
    end

    // Assemble architectural views; unimplemented bits read as zero
    always_comb begin
        statusRd                = '0;
        statusRd[5:0]           = statusLow_q;
        statusRd[8 +: NUM_IRQ]  = im_q;
        causeRd                 = '0;
        causeRd[6:2]            = excCode_q;
        causeRd[8 +: NUM_IRQ]   = ip_q;
        causeRd[31]             = bd_q;
    end

    // MFC0 read mux
    always_comb begin
        case (cp0_addr_i)
            CP0_STATUS: cp0_rdata_o = statusRd;
            CP0_CAUSE:  cp0_rdata_o = causeRd;
            CP0_EPC:    cp0_rdata_o = epc_q;
            default:    cp0_rdata_o = '0;
        endcase
    end

    assign exc_take_o     = take;
    assign exc_redirect_o = redirect_q;
    assign exc_pc_o       = EXC_VECTOR;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cp0_exc_ctrl
// Directed self-checking bench for cp0_exc_ctrl with default parameters
// (NUM_IRQ=8, DATA_W=32, EXC_VECTOR=0x80000080, FLUSH_CYC=2).
// Inputs change 2 time units after a rising edge; outputs are sampled one
// unit later, well clear of the next edge.
// ----------------------------------------------------------------------------
module tb_cp0_exc_ctrl;

    logic        clk;
    logic        reset;
    logic [7:0]  irq;
    logic        commitValid;
    logic [31:0] commitPc;
    logic        commitBd;
    logic        syscall, brk, ri, overflow, divzero, rfe;
    logic        cp0We;
    logic [4:0]  cp0Addr;
    logic [31:0] cp0Wdata;
    logic [31:0] cp0Rdata;
    logic        excTake;
    logic        excRedirect;
    logic [31:0] excPc;
    logic        excBusy;

    int checks = 0;
    int errors = 0;

    cp0_exc_ctrl dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .irq_i          (irq),
        .commit_valid_i (commitValid),
        .commit_pc_i    (commitPc),
        .commit_bd_i    (commitBd),
        .syscall_i      (syscall),
        .brk_i          (brk),
        .ri_i           (ri),
        .overflow_i     (overflow),
        .divzero_i      (divzero),
        .rfe_i          (rfe),
        .cp0_we_i       (cp0We),
        .cp0_addr_i     (cp0Addr),
        .cp0_wdata_i    (cp0Wdata),
        .cp0_rdata_o    (cp0Rdata),
        .exc_take_o     (excTake),
        .exc_redirect_o (excRedirect),
        .exc_pc_o       (excPc),
        .exc_busy_o     (excBusy)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Return every input to its idle value
    task automatic applyStimulus();
        commitValid = 1'b0;
        commitPc    = 32'h0;
        commitBd    = 1'b0;
        syscall     = 1'b0;
        brk         = 1'b0;
        ri          = 1'b0;
        overflow    = 1'b0;
        divzero     = 1'b0;
        rfe         = 1'b0;
        cp0We       = 1'b0;
        cp0Addr     = 5'd0;
        cp0Wdata    = 32'h0;
    endtask

    // MFC0 read and compare
    task automatic readCheck(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        cp0Addr = addr;
        #1;
        checkOutput(tag, cp0Rdata, exp);
    endtask

    // One-cycle MTC0 write
    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        cp0We    = 1'b1;
        cp0Addr  = addr;
        cp0Wdata = data;
        tick();
        cp0We    = 1'b0;
    endtask

    initial begin
        applyStimulus();
        irq   = 8'h00;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;

        // 1. Reset state
        readCheck("rst_status", 5'd12, 32'h0);
        readCheck("rst_cause", 5'd13, 32'h0);
        readCheck("rst_epc", 5'd14, 32'h0);
        checkOutput("rst_redirect", {31'b0, excRedirect}, 32'h0);
        checkOutput("rst_busy", {31'b0, excBusy}, 32'h0);

        // 2. Hardware interrupt on line 2
        tick();
        mtc0(5'd12, 32'h0000_0401);
        readCheck("t2_status", 5'd12, 32'h0000_0401);
        commitValid = 1'b1;
        commitPc    = 32'h0040_0000;
        irq         = 8'h04;
        #1;
        checkOutput("t2_take_early", {31'b0, excTake}, 32'h0);
        tick();
        #1;
        checkOutput("t2_take", {31'b0, excTake}, 32'h1);
        tick();
        commitValid = 1'b0;
        irq         = 8'h00;
        checkOutput("t2_redirect", {31'b0, excRedirect}, 32'h1);
        checkOutput("t2_busy", {31'b0, excBusy}, 32'h1);
        checkOutput("t2_excpc", excPc, 32'h8000_0080);
        readCheck("t2_status_push", 5'd12, 32'h0000_0404);
        readCheck("t2_cause", 5'd13, 32'h0000_0400);
        readCheck("t2_epc", 5'd14, 32'h0040_0000);
        tick();
        #1;
        checkOutput("t2_redirect_off", {31'b0, excRedirect}, 32'h0);
        checkOutput("t2_busy_2", {31'b0, excBusy}, 32'h1);
        tick();
        #1;
        checkOutput("t2_busy_off", {31'b0, excBusy}, 32'h0);

        // 3. Sync cause without commit is ignored; overflow beats syscall in a delay slot
        syscall = 1'b1;
        #1;
        checkOutput("t3_nocommit", {31'b0, excTake}, 32'h0);
        commitValid = 1'b1;
        commitPc    = 32'h0040_0100;
        commitBd    = 1'b1;
        overflow    = 1'b1;
        #1;
        checkOutput("t3_take", {31'b0, excTake}, 32'h1);
        tick();
        applyStimulus();
        readCheck("t3_cause", 5'd13, 32'h8000_0030);
        readCheck("t3_epc", 5'd14, 32'h0040_00FC);
        readCheck("t3_status", 5'd12, 32'h0000_0410);
        tick();
        tick();
        #1;
        checkOutput("t3_busy_off", {31'b0, excBusy}, 32'h0);

        // 4. Back-to-back syscalls: second blanked, third taken after FLUSH
        commitValid = 1'b1;
        syscall     = 1'b1;
        commitPc    = 32'h0050_0000;
        #1;
        checkOutput("t4_take1", {31'b0, excTake}, 32'h1);
        tick();
        commitPc = 32'h0050_0004;
        #1;
        checkOutput("t4_take2_blank", {31'b0, excTake}, 32'h0);
        checkOutput("t4_busy1", {31'b0, excBusy}, 32'h1);
        tick();
        commitPc = 32'h0050_0008;
        #1;
        checkOutput("t4_take_blank2", {31'b0, excTake}, 32'h0);
        checkOutput("t4_busy2", {31'b0, excBusy}, 32'h1);
        readCheck("t4_epc_first", 5'd14, 32'h0050_0000);
        tick();
        #1;
        checkOutput("t4_busy_off", {31'b0, excBusy}, 32'h0);
        checkOutput("t4_take3", {31'b0, excTake}, 32'h1);
        tick();
        applyStimulus();
        readCheck("t4_epc_third", 5'd14, 32'h0050_0008);
        readCheck("t4_cause", 5'd13, 32'h0000_0020);
        readCheck("t4_status", 5'd12, 32'h0000_0400);
        tick();
        tick();

        // 5. RFE pops the KU/IE stack; RFE beats a same-cycle MTC0
        cp0We    = 1'b1;
        cp0Addr  = 5'd12;
        cp0Wdata = 32'h0000_003C;
        #1;
        checkOutput("t5_mfc0_old", cp0Rdata, 32'h0000_0400);
        tick();
        cp0We = 1'b0;
        readCheck("t5_status_wr", 5'd12, 32'h0000_003C);
        commitValid = 1'b1;
        rfe         = 1'b1;
        tick();
        readCheck("t5_rfe", 5'd12, 32'h0000_003F);
        cp0We    = 1'b1;
        cp0Addr  = 5'd12;
        cp0Wdata = 32'h0000_0000;
        tick();
        applyStimulus();
        readCheck("t5_rfe_vs_mtc0", 5'd12, 32'h0000_003F);

        // 6. Software interrupt via MTC0 Cause, then reset during FLUSH
        mtc0(5'd12, 32'h0000_0101);
        irq = 8'h08;
        mtc0(5'd13, 32'h0000_0100);
        irq = 8'h00;
        readCheck("t6_cause_sw_hw", 5'd13, 32'h0000_0920);
        commitValid = 1'b1;
        commitPc    = 32'h0060_0000;
        #1;
        checkOutput("t6_take", {31'b0, excTake}, 32'h1);
        tick();
        commitValid = 1'b0;
        readCheck("t6_cause", 5'd13, 32'h0000_0100);
        checkOutput("t6_redirect", {31'b0, excRedirect}, 32'h1);
        checkOutput("t6_busy", {31'b0, excBusy}, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checkOutput("t6_rst_busy", {31'b0, excBusy}, 32'h0);
        checkOutput("t6_rst_redirect", {31'b0, excRedirect}, 32'h0);
        readCheck("t6_rst_status", 5'd12, 32'h0);
        readCheck("t6_rst_cause", 5'd13, 32'h0);
        readCheck("t6_rst_epc", 5'd14, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
